fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Two-producer write arbiter and occupancy controller for the shared `fifo` queue in the npc front end. It grants one writer per cycle round-robin and tags each entry with its source ID. It tracks occupancy to produce full and empty flags, since the fifo reports only empty. It also sequences queue flushes through a small state machine so that no handshake overlaps a flush.

## Interface
Parameters:
- DATA_LEN, 32, payload width per producer.
- AddR_Width, 6, fifo address width; depth DEPTH = 2**AddR_Width; must equal the attached fifo's AddR_Width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low; sampled on posedge clk.
- in0_valid / in1_valid  in  1  producer 0/1 has data.
- in0_data / in1_data  in  DATA_LEN  producer payloads.
- in0_ready / in1_ready  out  1  write accepted this cycle when valid&ready.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  consumer takes head.
- out_data  out  DATA_LEN  head payload, = fifo_rdata[DATA_LEN-1:0].
- out_src  out  1  head source ID, = fifo_rdata[DATA_LEN].
- flush  in  1  discard all queued entries.
- full  out  1  count == DEPTH.
- count  out  AddR_Width+1  current occupancy, 0..DEPTH.
- fifo_wready  out  1  to fifo Wready.
- fifo_rready  out  1  to fifo Rready.
- fifo_flush  out  1  to fifo flush.
- fifo_wdata  out  DATA_LEN+1  to fifo wdata, {src, payload}.
- fifo_rdata  in  DATA_LEN+1  from fifo rdata.

## Operation
- FSM states are RUN and FLUSH. Reset state is RUN.
- Transitions:
  - RUN -> FLUSH when flush=1.
  - FLUSH -> RUN when flush=0.
  - FLUSH -> FLUSH while flush stays 1.
- Accept enable: acc_en = (state==RUN) && !flush && !full.
- Arbitration uses a 1-bit rr pointer; rr=0 gives port 0 priority.
  - Grant goes to the only valid port, or to the priority port when both are valid.
  - in0_ready = acc_en && in0_valid && (!in1_valid || rr==0); in1_ready is symmetric.
  - At most one ready is high per cycle. A non-granted ready is 0.
- On a grant to port p, rr <= ~p. With no grant, rr holds.
- fifo_wready = in0_ready|in1_ready.
- fifo_wdata = {1'b0,in0_data} when port 0 is granted, else {1'b1,in1_data}.
- out_valid = (state==RUN) && !flush && (count!=0).
- fifo_rready = out_valid && out_ready.
- count update, where w = fifo_wready and r = fifo_rready:
  - count <= count + w - r.
  - A simultaneous write and read leaves count unchanged.
  - In FLUSH, count <= 0.
- fifo_flush = (state==FLUSH). In FLUSH, all readies, out_valid, fifo_wready and fifo_rready are 0.
- Full with a concurrent read: the write is still blocked (no bypass). Ready never depends on out_ready.
- Empty with a concurrent write: out_valid stays 0 that cycle (no pass-through).

## Timing
- Reset values (rstn=0 at posedge):
  - state=RUN, count=0, rr=0.
  - Next cycle: out_valid=0, full=0, fifo_flush=0, fifo_wready=0, fifo_rready=0, in*_ready=0.
- Reset asserted mid-operation clears count, rr and state in one edge. Ready outputs are only meaningful after rstn=1, so the bench must check them at reset-deassert.
- Write latency: entry accepted at edge N gives out_valid=1 in cycle N+1, with out_data/out_src valid.
- Flush timing:
  - flush=1 in cycle N blocks all handshakes in cycle N.
  - FLUSH is active in cycle N+1 with fifo_flush=1.
  - count=0 from cycle N+2; RUN resumes in N+2 if flush has dropped.
- Combinational paths are in*_valid/flush/count -> readies and flush/count -> out_valid. There is no path from out_ready to in*_ready.
- count never exceeds DEPTH and never underflows. The bench asserts both every cycle.

## Test plan
- **Reset:** hold rstn=0 for 3 cycles, then release. Expect count=0, full=0, out_valid=0, rr=0, fifo_flush=0.
- **Single writer:** AddR_Width=2 (DEPTH=4), in0_valid=1 with data 0x11, 0x22, 0x33, 0x44, 0x55 and out_ready=0.
  - First four accepted; count=4, full=1, in0_ready=0 for 0x55.
  - Then out_ready=1: drain order is 0x11..0x44 with out_src=0, then 0x55 is accepted.
- **Round-robin:** both valid every cycle, in0 = 0xA0+i, in1 = 0xB0+i, out_ready=1.
  - Grants alternate 0,1,0,1.
  - Output sequence 0xA0/src0, 0xB0/src1, 0xA1/src0, 0xB1/src1.
- **Simultaneous read and write:** count=2, in1 writes 0x77 while out_ready=1.
  - count stays 2; 0x77 emerges after the two older entries.
- **Flush:** count=3, assert flush for 1 cycle while in0_valid=1 and out_ready=1.
  - No handshake in the flush cycle; fifo_flush=1 the next cycle; count=0, out_valid=0 after.
  - A new write of 0x99 appears as the next out_data.
- **Full with read:** count=4, in0_valid=1 and out_ready=1.
  - Read occurs, in0_ready=0, count=3.
  - Next cycle the write is accepted.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Two-producer write arbiter and occupancy controller for the shared npc
// front-end fifo. One producer is granted per cycle, round-robin. Each entry
// is tagged with its source ID in the top bit of the fifo word. Occupancy is
// tracked here because the fifo itself only reports empty. Flushes are
// sequenced through a RUN/FLUSH state machine so that no handshake can overlap
// a flush.
//
// Parameters
//   DATA_LEN    payload width per producer
//   AddR_Width  fifo address width; DEPTH = 2**AddR_Width
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   in0_valid/data/ready      producer 0 handshake
//   in1_valid/data/ready      producer 1 handshake
//   out_valid/ready/data/src  consumer side; data/src are sliced from fifo_rdata
//   flush                     discard all queued entries
//   full, count               occupancy status (count is 0..DEPTH)
//   fifo_wready/rready/flush  strobes to the attached fifo
//   fifo_wdata                {src, payload} written to the fifo
//   fifo_rdata                {src, payload} at the fifo head
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_LEN   = 32,
  parameter int AddR_Width = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in0_valid,
  input  logic [DATA_LEN-1:0]   in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [DATA_LEN-1:0]   in1_data,
  output logic                  in1_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_LEN-1:0]   out_data,
  output logic                  out_src,
  input  logic                  flush,
  output logic                  full,
  output logic [AddR_Width:0]   count,
  output logic                  fifo_wready,
  output logic                  fifo_rready,
  output logic                  fifo_flush,
  output logic [DATA_LEN:0]     fifo_wdata,
  input  logic [DATA_LEN:0]     fifo_rdata
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // DEPTH = 2**AddR_Width, expressed directly in count width.
  localparam logic [AddR_Width:0] DEPTH   = {1'b1, {AddR_Width{1'b0}}};
  localparam logic [AddR_Width:0] CNT_ONE = {{AddR_Width{1'b0}}, 1'b1};

  logic [0:0]          r_state;
  logic [AddR_Width:0] r_count;
  logic                r_rr;      // 0: port 0 has priority, 1: port 1

  logic                w_run;
  logic                w_acc_en;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_wr;
  logic                w_rd;
  logic [AddR_Width:0] w_count_nxt;

  // A flush request blocks every handshake in the cycle it is raised, before
  // the state machine has even moved to FLUSH.
  assign w_run    = (r_state == ST_RUN) && !flush;
  assign full     = (r_count == DEPTH);
  assign w_acc_en = w_run && !full;

  // Priority port wins only on contention; a lone valid port always wins.
  // Readies never look at out_ready, so a full queue stays closed even when
  // the head is being read in the same cycle.
  assign w_grant0 = w_acc_en && in0_valid && (!in1_valid || !r_rr);
  assign w_grant1 = w_acc_en && in1_valid && (!in0_valid ||  r_rr);

  assign in0_ready   = w_grant0;
  assign in1_ready   = w_grant1;
  assign w_wr        = w_grant0 || w_grant1;
  assign fifo_wready = w_wr;
  assign fifo_wdata  = w_grant0 ? {1'b0, in0_data} : {1'b1, in1_data};

  // Head is only exposed once it is registered in count: a write into an
  // empty queue does not pass through in the same cycle.
  assign out_valid   = w_run && (r_count != '0);
  assign w_rd        = out_valid && out_ready;
  assign fifo_rready = w_rd;
  assign out_data    = fifo_rdata[DATA_LEN-1:0];
  assign out_src     = fifo_rdata[DATA_LEN];

  assign fifo_flush  = (r_state == ST_FLUSH);
  assign count       = r_count;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_rr    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:   if (flush)  r_state <= ST_FLUSH;
        ST_FLUSH: if (!flush) r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase

      if (r_state == ST_FLUSH) begin
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
      end

      // Priority passes to the port that was not just served.
      if (w_grant0) begin
        r_rr <= 1'b1;
      end else if (w_grant1) begin
        r_rr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter with DEPTH=4. The attached fifo is a queue driven
// by the DUT strobes. A separate reference queue tracks what the arbiter
// should have accepted and delivered, from the arbitration/flush rules.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int DATA_LEN   = 32;
  localparam int AddR_Width = 2;
  localparam int DEPTH      = 2**AddR_Width;

  logic                 clk;
  logic                 rstn;
  logic                 in0_valid, in1_valid;
  logic [DATA_LEN-1:0]  in0_data, in1_data;
  logic                 in0_ready, in1_ready;
  logic                 out_valid, out_ready;
  logic [DATA_LEN-1:0]  out_data;
  logic                 out_src;
  logic                 flush;
  logic                 full;
  logic [AddR_Width:0]  count;
  logic                 fifo_wready, fifo_rready, fifo_flush;
  logic [DATA_LEN:0]    fifo_wdata;
  logic [DATA_LEN:0]    fifo_rdata;

  fifo_wr_arbiter #(.DATA_LEN(DATA_LEN), .AddR_Width(AddR_Width)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in0_valid  (in0_valid),
    .in0_data   (in0_data),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_ready  (in1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .flush      (flush),
    .full       (full),
    .count      (count),
    .fifo_wready(fifo_wready),
    .fifo_rready(fifo_rready),
    .fifo_flush (fifo_flush),
    .fifo_wdata (fifo_wdata),
    .fifo_rdata (fifo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Attached fifo (driven by DUT strobes) and reference contents.
  logic [DATA_LEN:0] fq[$];
  logic [DATA_LEN:0] m_q[$];
  int                m_pref;        // port that wins on contention
  bit                m_prev_flush;  // flush was sampled high at the last edge

  // Values observed at the most recent negedge.
  logic              cap_r0, cap_r1, cap_full, cap_ovalid, cap_osrc;
  logic              cap_rready, cap_wready, cap_fflush;
  logic [AddR_Width:0] cap_count;
  logic [DATA_LEN-1:0] cap_odata;
  logic [DATA_LEN:0]   cap_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check at negedge, then advance both models past posedge.
  task automatic step();
    bit run, e_full, acc, e_ov, e_rd;
    int g;
    logic [DATA_LEN:0] e_wdata;
    @(negedge clk);
    cap_r0 = in0_ready;  cap_r1 = in1_ready;  cap_full = full;
    cap_ovalid = out_valid;  cap_osrc = out_src;  cap_odata = out_data;
    cap_rready = fifo_rready;  cap_wready = fifo_wready;
    cap_fflush = fifo_flush;  cap_count = count;  cap_wdata = fifo_wdata;

    run    = !m_prev_flush && !flush;
    e_full = (m_q.size() == DEPTH);
    acc    = run && !e_full;
    g = -1;
    if (acc) begin
      if (in0_valid && in1_valid) g = m_pref;
      else if (in0_valid)         g = 0;
      else if (in1_valid)         g = 1;
    end
    e_ov = run && (m_q.size() != 0);
    e_rd = e_ov && out_ready;
    e_wdata = (g == 1) ? {1'b1, in1_data} : {1'b0, in0_data};

    chk("count",       64'(cap_count),  64'(m_q.size()));
    chk("count_bound", 64'(cap_count <= DEPTH), 64'd1);
    chk("full",        64'(cap_full),   64'(e_full));
    chk("in0_ready",   64'(cap_r0),     64'(g == 0));
    chk("in1_ready",   64'(cap_r1),     64'(g == 1));
    chk("fifo_wready", 64'(cap_wready), 64'(g >= 0));
    chk("out_valid",   64'(cap_ovalid), 64'(e_ov));
    chk("fifo_rready", 64'(cap_rready), 64'(e_rd));
    chk("fifo_flush",  64'(cap_fflush), 64'(m_prev_flush));
    if (g >= 0) chk("fifo_wdata", 64'(cap_wdata), 64'(e_wdata));
    if (e_ov) begin
      chk("out_data", 64'(cap_odata), 64'(m_q[0][DATA_LEN-1:0]));
      chk("out_src",  64'(cap_osrc),  64'(m_q[0][DATA_LEN]));
    end

    @(posedge clk);
    #1;
    if (!rstn) begin
      fq.delete();
      m_q.delete();
      m_pref = 0;
      m_prev_flush = 1'b0;
    end else begin
      if (cap_fflush) fq.delete();
      else begin
        if (cap_rready && fq.size() > 0) void'(fq.pop_front());
        if (cap_wready) fq.push_back(cap_wdata);
      end
      if (m_prev_flush) m_q.delete();
      else begin
        if (e_rd) void'(m_q.pop_front());
        if (g >= 0) begin
          m_q.push_back(e_wdata);
          m_pref = 1 - g;
        end
      end
      m_prev_flush = flush;
    end
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0;  in1_valid = 1'b0;
    out_ready = 1'b0;  flush = 1'b0;
  endtask

  initial begin
    int i0, i1;
    logic [7:0] vals [5];
    rstn = 1'b0;
    idle_inputs();
    in0_data = '0;  in1_data = '0;
    fifo_rdata = '0;
    m_pref = 0;
    m_prev_flush = 1'b0;

    // Reset held 3 cycles, then released.
    repeat (3) step();
    rstn = 1'b1;
    in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 32'hC0; in1_data = 32'hD0;
    flush = 1'b1;
    step();
    chk("rst_count",     64'(cap_count),  64'd0);
    chk("rst_full",      64'(cap_full),   64'd0);
    chk("rst_out_valid", 64'(cap_ovalid), 64'd0);
    chk("rst_fifo_flush",64'(cap_fflush), 64'd0);
    flush = 1'b0;
    step();                                    // FLUSH cycle from the probe
    step();
    chk("rst_rr_port0",  64'(cap_r0),     64'd1);
    idle_inputs();
    rstn = 1'b0; step(); rstn = 1'b1;

    // Single writer into DEPTH=4 with the consumer stalled.
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    in0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 32'(vals[k]);
      step();
      chk("sw_accept", 64'(cap_r0), 64'd1);
    end
    in0_data = 32'h55;
    step();
    chk("sw_blocked", 64'(cap_r0),    64'd0);
    chk("sw_full",    64'(cap_full),  64'd1);
    chk("sw_count4",  64'(cap_count), 64'd4);
    out_ready = 1'b1;
    step();
    chk("sw_nobypass", 64'(cap_r0),    64'd0);
    chk("sw_drain0",   64'(cap_odata), 64'h11);
    step();
    chk("sw_accept55", 64'(cap_r0),    64'd1);
    chk("sw_drain1",   64'(cap_odata), 64'h22);
    in0_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      step();
      chk("sw_drain", 64'(cap_odata), 64'(vals[k]));
      chk("sw_src0",  64'(cap_osrc),  64'd0);
    end
    step();

    // Round-robin from a fresh pointer.
    rstn = 1'b0; step(); rstn = 1'b1;
    i0 = 0; i1 = 0;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in0_data = 32'(8'hA0 + i0);
      in1_data = 32'(8'hB0 + i1);
      step();
      chk("rr_grant", 64'(cap_r1), 64'(k % 2));
      if (k > 0) begin
        chk("rr_out_data", 64'(cap_odata), (k % 2 == 1) ? 64'hA0 + 64'((k - 1) / 2) : 64'hB0 + 64'((k - 1) / 2));
        chk("rr_out_src",  64'(cap_osrc),  64'((k - 1) % 2));
      end
      if (cap_r0) i0++;
      if (cap_r1) i1++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    step();
    chk("rr_last", 64'(cap_odata), 64'hB1);
    step();

    // Simultaneous read and write at count=2.
    in0_valid = 1'b1; out_ready = 1'b0;
    in0_data = 32'h61; step();
    in0_data = 32'h62; step();
    in0_valid = 1'b0; in1_valid = 1'b1; in1_data = 32'h77; out_ready = 1'b1;
    step();
    chk("rw_write", 64'(cap_r1),     64'd1);
    chk("rw_read",  64'(cap_rready), 64'd1);
    in1_valid = 1'b0;
    step();
    chk("rw_count2", 64'(cap_count), 64'd2);
    chk("rw_order1", 64'(cap_odata), 64'h62);
    step();
    chk("rw_77",     64'(cap_odata), 64'h77);
    chk("rw_77_src", 64'(cap_osrc),  64'd1);
    step();

    // Flush with three queued entries.
    in0_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in0_data = 32'(8'h31 + k);
      step();
    end
    flush = 1'b1; in0_data = 32'h44; out_ready = 1'b1;
    step();
    chk("fl_no_write", 64'(cap_r0),     64'd0);
    chk("fl_no_read",  64'(cap_rready), 64'd0);
    flush = 1'b0;
    step();
    chk("fl_active",   64'(cap_fflush), 64'd1);
    chk("fl_state_rd", 64'(cap_r0),     64'd0);
    in0_valid = 1'b0;
    step();
    chk("fl_count0", 64'(cap_count),  64'd0);
    chk("fl_ovalid", 64'(cap_ovalid), 64'd0);
    in0_valid = 1'b1; in0_data = 32'h99;
    step();
    chk("fl_new_wr", 64'(cap_r0), 64'd1);
    in0_valid = 1'b0;
    step();
    chk("fl_99", 64'(cap_odata), 64'h99);
    step();

    // Full with a concurrent read.
    in0_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in0_data = 32'(8'hE0 + k);
      step();
    end
    in0_data = 32'hF5; out_ready = 1'b1;
    step();
    chk("fr_read",    64'(cap_rready), 64'd1);
    chk("fr_blocked", 64'(cap_r0),     64'd0);
    step();
    chk("fr_count3",  64'(cap_count),  64'd3);
    chk("fr_accept",  64'(cap_r0),     64'd1);
    in0_valid = 1'b0;
    repeat (5) step();

    // Randomized traffic including flushes and occasional resets.
    for (int n = 0; n < 600; n++) begin
      rstn      = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in0_valid = $urandom_range(0, 1) == 1;
      in1_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) == 0;
      in0_data  = $urandom;
      in1_data  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
